// File: rtl/simon_pkg.sv
// Shared types, z-sequence constants and rotate helpers for the Simon cipher cores.
// Rotate helpers work on a MAX_W container; callers zero-extend into it and truncate the result.
package simon_pkg;

    localparam int MAX_W = 64;

    // z-sequences in sequence order: sequence bit i sits at [61-i].
    localparam logic [61:0] Z0 = 62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] Z1 = 62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [61:0] Z4 = 62'b11010001111001101011011000100000010111000011001010010011101111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
        logic [MAX_W-1:0] m;
        if (w >= MAX_W) begin
            m = {MAX_W{1'b1}};
        end else begin
            m = (MAX_W'(1'b1) << w) - MAX_W'(1'b1);
        end
        return m;
    endfunction

    function automatic logic [MAX_W-1:0] rol(input logic [MAX_W-1:0] v,
                                             input int unsigned w,
                                             input int unsigned s);
        logic [MAX_W-1:0] m;
        logic [MAX_W-1:0] vm;
        logic [MAX_W-1:0] r;
        int unsigned      sh;
        m  = width_mask(w);
        vm = v & m;
        sh = s % w;
        if (sh == 32'd0) begin
            r = vm;
        end else begin
            r = ((vm << sh) | (vm >> (w - sh))) & m;
        end
        return r;
    endfunction

    function automatic logic [MAX_W-1:0] ror(input logic [MAX_W-1:0] v,
                                             input int unsigned w,
                                             input int unsigned s);
        logic [MAX_W-1:0] m;
        logic [MAX_W-1:0] vm;
        logic [MAX_W-1:0] r;
        int unsigned      sh;
        m  = width_mask(w);
        vm = v & m;
        sh = s % w;
        if (sh == 32'd0) begin
            r = vm;
        end else begin
            r = ((vm >> sh) | (vm << (w - sh))) & m;
        end
        return r;
    endfunction

endpackage

// File: rtl/simon_iter_core_key_sched.sv
// On-the-fly Simon key schedule: holds the m key words and the z index,
// shifting in one freshly derived key word per round.
module simon_key_sched
    import simon_pkg::*;
#(
    parameter int          WORD_W    = 32,
    parameter int          KEY_WORDS = 4,
    parameter logic [61:0] Z_CONST   = Z3
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          load,
    input  logic                          step,
    input  logic [KEY_WORDS*WORD_W-1:0]   key,
    output logic [WORD_W-1:0]             k0
);

    logic [WORD_W-1:0] kr_r [KEY_WORDS];
    logic [5:0]        zi_r;
    logic [WORD_W-1:0] t_s;
    logic [WORD_W-1:0] tf_s;
    logic [WORD_W-1:0] knew_s;
    logic              z_bit_s;

    // Derive the key word that enters at the top of the window this round.
    always_comb begin
        t_s = WORD_W'(ror(MAX_W'(kr_r[KEY_WORDS-1]), WORD_W, 32'd3));
        if (KEY_WORDS == 4) begin
            t_s = t_s ^ kr_r[1];
        end else begin
            t_s = t_s;
        end
        tf_s    = t_s ^ WORD_W'(ror(MAX_W'(t_s), WORD_W, 32'd1));
        z_bit_s = Z_CONST[6'd61 - zi_r];
        knew_s  = ~kr_r[0] ^ tf_s ^ WORD_W'(z_bit_s) ^ WORD_W'(2'd3);
    end

    // Key window and z index: load on accept, slide one word per round.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int j = 0; j < KEY_WORDS; j++) begin
                kr_r[j] <= '0;
            end
            zi_r <= 6'd0;
        end else if (load) begin
            for (int j = 0; j < KEY_WORDS; j++) begin
                kr_r[j] <= key[j*WORD_W +: WORD_W];
            end
            zi_r <= 6'd0;
        end else if (step) begin
            for (int j = 0; j < KEY_WORDS - 1; j++) begin
                kr_r[j] <= kr_r[j+1];
            end
            kr_r[KEY_WORDS-1] <= knew_s;
            zi_r <= (zi_r == 6'd61) ? 6'd0 : zi_r + 6'd1;
        end
    end

    assign k0 = kr_r[0];

endmodule

// File: rtl/simon_iter_core.sv
// Iterative Simon encryption core: one Feistel round per clock, valid/ready on both sides.
// FSM IDLE -> RUN (ROUNDS cycles) -> DONE; handshake outputs come straight from registers.
module simon_iter_core
    import simon_pkg::*;
#(
    parameter int          WORD_W    = 32,
    parameter int          KEY_WORDS = 4,
    parameter int          ROUNDS    = 44,
    parameter logic [61:0] Z_CONST   = Z3
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [KEY_WORDS*WORD_W-1:0]   key,
    input  logic [2*WORD_W-1:0]           plain_text,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2*WORD_W-1:0]           cipher_text
);

    if (KEY_WORDS < 2 || KEY_WORDS > 4) begin : g_bad_key_words
        $error("simon_iter_core: KEY_WORDS must be 2, 3 or 4");
    end
    if (ROUNDS < KEY_WORDS) begin : g_bad_rounds
        $error("simon_iter_core: ROUNDS must be >= KEY_WORDS");
    end
    if (WORD_W < 9 || WORD_W > MAX_W) begin : g_bad_word_w
        $error("simon_iter_core: WORD_W out of range");
    end

    localparam int              RC_W    = $clog2(ROUNDS + 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(ROUNDS - 1);

    state_t              state_r;
    state_t              state_next_s;
    logic                load_s;
    logic                step_s;
    logic                last_round_s;
    logic                in_ready_r;
    logic                out_valid_r;
    logic [RC_W-1:0]     rc_r;
    logic [WORD_W-1:0]   x_r;
    logic [WORD_W-1:0]   y_r;
    logic [WORD_W-1:0]   x_next_s;
    logic [WORD_W-1:0]   k0_s;
    logic [2*WORD_W-1:0] cipher_r;

    simon_key_sched #(
        .WORD_W    (WORD_W),
        .KEY_WORDS (KEY_WORDS),
        .Z_CONST   (Z_CONST)
    ) u_key_sched (
        .clk  (clk),
        .rstn (rstn),
        .load (load_s),
        .step (step_s),
        .key  (key),
        .k0   (k0_s)
    );

    assign last_round_s = (rc_r == RC_LAST);

    // Next-state and datapath control decode.
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next_s = ST_RUN;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                step_s = 1'b1;
                if (last_round_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register plus handshake flags registered from the next state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == ST_IDLE);
            out_valid_r <= (state_next_s == ST_DONE);
        end
    end

    // One Simon round: x' = y ^ f(x) ^ k, y' = x.
    always_comb begin
        x_next_s = WORD_W'(MAX_W'(y_r)
                 ^ (rol(MAX_W'(x_r), WORD_W, 32'd1) & rol(MAX_W'(x_r), WORD_W, 32'd8))
                 ^ rol(MAX_W'(x_r), WORD_W, 32'd2)
                 ^ MAX_W'(k0_s));
    end

    // Round state, round counter and the held result.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            x_r      <= '0;
            y_r      <= '0;
            rc_r     <= '0;
            cipher_r <= '0;
        end else if (load_s) begin
            x_r  <= plain_text[2*WORD_W-1:WORD_W];
            y_r  <= plain_text[WORD_W-1:0];
            rc_r <= '0;
        end else if (step_s) begin
            x_r  <= x_next_s;
            y_r  <= x_r;
            rc_r <= rc_r + RC_W'(1'b1);
            if (last_round_s) begin
                cipher_r <= {x_next_s, x_r};
            end
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign cipher_text = cipher_r;

endmodule

// File: tb/tb_simon_iter_core.sv
// Directed bench for simon_iter_core: Simon64/128 and Simon32/64 known answers,
// handshake timing, backpressure, input hazards and mid-run reset.
module tb_simon_iter_core;

    localparam logic [127:0] K64 = 128'h1b1a1918_13121110_0b0a0908_03020100;
    localparam logic [63:0]  P64 = 64'h656b696c_20646e75;
    localparam logic [63:0]  C64 = 64'h44c8fc20_b9dfa07a;
    localparam logic [63:0]  K32 = 64'h1918_1110_0908_0100;
    localparam logic [31:0]  P32 = 32'h6565_6877;
    localparam logic [31:0]  C32 = 32'hc69b_e9bb;

    logic         clk = 1'b0;
    logic         rstn;
    logic         iv64, ir64, ov64, or64;
    logic [127:0] k64;
    logic [63:0]  p64, c64;
    logic         iv32, ir32, ov32, or32;
    logic [63:0]  k32;
    logic [31:0]  p32, c32;

    int total = 0;
    int bad   = 0;
    int lat;
    int acc;

    always #5 clk = ~clk;

    simon_iter_core dut64 (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid    (iv64),
        .in_ready    (ir64),
        .key         (k64),
        .plain_text  (p64),
        .out_valid   (ov64),
        .out_ready   (or64),
        .cipher_text (c64)
    );

    simon_iter_core #(
        .WORD_W    (16),
        .KEY_WORDS (4),
        .ROUNDS    (32),
        .Z_CONST   (simon_pkg::Z0)
    ) dut32 (
        .clk         (clk),
        .rstn        (rstn),
        .in_valid    (iv32),
        .in_ready    (ir32),
        .key         (k32),
        .plain_text  (p32),
        .out_valid   (ov32),
        .out_ready   (or32),
        .cipher_text (c32)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one block on dut64; returns just after the accept edge.
    task automatic start64(input logic [127:0] k, input logic [63:0] p);
        int n;
        n = 0;
        while (!ir64 && n < 200) begin
            tick();
            n++;
        end
        chk("start_ready", ir64, 1'b1);
        k64  = k;
        p64  = p;
        iv64 = 1'b1;
        tick();
        iv64 = 1'b0;
    endtask

    task automatic wait_out64(output int l);
        l = 0;
        while (!ov64 && l < 400) begin
            tick();
            l++;
        end
    endtask

    initial begin
        rstn = 1'b0;
        iv64 = 1'b0; or64 = 1'b1; k64 = '0; p64 = '0;
        iv32 = 1'b0; or32 = 1'b1; k32 = '0; p32 = '0;
        tick();
        tick();
        chk("rst_in_ready",   ir64, 1'b1);
        chk("rst_out_valid",  ov64, 1'b0);
        chk("rst_cipher",     c64,  64'h0);
        chk("rst_in_ready32", ir32, 1'b1);
        chk("rst_cipher32",   c32,  32'h0);
        rstn = 1'b1;
        tick();

        // Simon64/128 known answer with latency and single-cycle out_valid pulse.
        start64(K64, P64);
        wait_out64(lat);
        chk("kat64_latency", lat, 44);
        chk("kat64_cipher",  c64, C64);
        tick();
        chk("kat64_pulse_end", ov64, 1'b0);
        chk("kat64_ready_back", ir64, 1'b1);

        // Simon32/64 known answer.
        k32  = K32;
        p32  = P32;
        iv32 = 1'b1;
        tick();
        iv32 = 1'b0;
        lat  = 0;
        while (!ov32 && lat < 400) begin
            tick();
            lat++;
        end
        chk("kat32_latency", lat, 32);
        chk("kat32_cipher",  c32, C32);
        tick();

        // Backpressure: DONE held with an offer pending, then simultaneous release and offer.
        or64 = 1'b0;
        start64(K64, P64);
        wait_out64(lat);
        chk("bp_latency", lat, 44);
        k64  = K64;
        p64  = P64;
        iv64 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("bp_hold", {ov64, ir64, c64}, {1'b1, 1'b0, C64});
        end
        or64 = 1'b1;
        tick();
        chk("bp_release_idle", {ov64, ir64}, {1'b0, 1'b1});
        tick();
        iv64 = 1'b0;
        chk("bp_second_accepted", ir64, 1'b0);
        wait_out64(lat);
        chk("bp_second_latency", lat, 44);
        chk("bp_second_cipher",  c64, C64);
        tick();

        // in_valid held through RUN with changing key/plain_text.
        k64  = K64;
        p64  = P64;
        iv64 = 1'b1;
        acc  = (ir64 && iv64) ? 1 : 0;
        tick();
        lat = 0;
        while (!ov64 && lat < 400) begin
            k64 = {$urandom(), $urandom(), $urandom(), $urandom()};
            p64 = {$urandom(), $urandom()};
            if (ir64 && iv64) acc++;
            tick();
            lat++;
        end
        iv64 = 1'b0;
        chk("hz_latency", lat, 44);
        chk("hz_cipher",  c64, C64);
        chk("hz_accepts", acc, 1);
        tick();

        // Back-to-back blocks at peak throughput.
        k64  = K64;
        p64  = P64;
        iv64 = 1'b1;
        tick();
        wait_out64(lat);
        chk("b2b_first_latency", lat, 44);
        chk("b2b_first_cipher",  c64, C64);
        tick();
        lat = 1;
        while (!ov64 && lat < 400) begin
            tick();
            lat++;
        end
        iv64 = 1'b0;
        chk("b2b_period",        lat, 46);
        chk("b2b_second_cipher", c64, C64);
        tick();

        // Reset at round 10 discards the block.
        start64(K64, P64);
        repeat (10) tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("mid_rst_in_ready",  ir64, 1'b1);
        chk("mid_rst_out_valid", ov64, 1'b0);
        chk("mid_rst_cipher",    c64,  64'h0);
        start64(K64, P64);
        wait_out64(lat);
        chk("post_rst_latency", lat, 44);
        chk("post_rst_cipher",  c64, C64);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
